// File: rtl/br_resolve_arb_pkg.sv
// ============================================================================
// Module  : br_resolve_arb_pkg
// Brief   : Shared branch-resolution widths and state encodings.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package br_resolve_arb_pkg;

    localparam int BR_MASK_W  = 4;
    localparam int BR_STATE_W = 2;

    localparam logic [1:0] BR_NONE       = 2'b00;
    localparam logic [1:0] BR_PR_CORRECT = 2'b01;
    localparam logic [1:0] BR_PR_WRONG   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/br_oldest_sel.sv
// ============================================================================
// Module  : br_oldest_sel
// Brief   : Picks the oldest wrong candidate, else the lowest-index correct one.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module br_oldest_sel #(
    parameter int W = 4
) (
    input  logic [W-1:0]   cand_valid,
    input  logic [W-1:0]   cand_wrong,
    input  logic [W*W-1:0] cand_dep,
    output logic           sel_any,
    output logic           sel_wrong,
    output logic [W-1:0]   sel_bit
);

    localparam logic [W-1:0] c_one = {{(W-1){1'b0}}, 1'b1};

    logic [W-1:0] w_wrong_vec;
    logic [W-1:0] w_correct_vec;
    logic [W-1:0] w_oldest;
    logic [W-1:0] w_pool;

    always_comb begin
        w_wrong_vec   = cand_valid & cand_wrong;
        w_correct_vec = cand_valid & ~cand_wrong;
        w_oldest      = '0;
        // A wrong candidate is oldest when no other wrong candidate is in its dep mask
        for (int i = 0; i < W; i++) begin
            w_oldest[i] = w_wrong_vec[i] && ((cand_dep[i*W +: W] & w_wrong_vec) == '0);
        end
        sel_wrong = |w_wrong_vec;
        sel_any   = |cand_valid;
        if (sel_wrong) begin
            w_pool = (|w_oldest) ? w_oldest : w_wrong_vec;
        end else begin
            w_pool = w_correct_vec;
        end
        sel_bit = w_pool & (~w_pool + c_one);
    end

endmodule

`default_nettype wire

// File: rtl/br_resolve_arb.sv
// ============================================================================
// Module  : br_resolve_arb
// Brief   : Collects resolved branches from FU ports and issues one per cycle.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module br_resolve_arb #(
    parameter int BR_MASK_W   = br_resolve_arb_pkg::BR_MASK_W,
    parameter int NUM_BR_PORT = 2,
    parameter int BR_STATE_W  = br_resolve_arb_pkg::BR_STATE_W
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_BR_PORT-1:0]         fu_br_valid_i,
    input  logic [NUM_BR_PORT-1:0]         fu_br_wrong_i,
    input  logic [NUM_BR_PORT*BR_MASK_W-1:0] fu_br_bit_i,
    input  logic [NUM_BR_PORT*BR_MASK_W-1:0] fu_br_dep_mask_i,
    output logic [BR_STATE_W-1:0]          br_state_o,
    output logic [BR_MASK_W-1:0]           br_bit_o,
    output logic [BR_MASK_W-1:0]           br_dep_mask_o,
    output logic [BR_MASK_W-1:0]           pend_o
);

    import br_resolve_arb_pkg::BR_NONE;
    import br_resolve_arb_pkg::BR_PR_CORRECT;
    import br_resolve_arb_pkg::BR_PR_WRONG;

    localparam int W = BR_MASK_W;

    logic [W-1:0]          r_tv;
    logic [W-1:0]          r_tw;
    logic [W*W-1:0]        r_td;
    logic [BR_STATE_W-1:0] r_state;
    logic [W-1:0]          r_bit;
    logic [W-1:0]          r_dep;

    logic [W-1:0]   w_clr;
    logic [W-1:0]   w_kill;
    logic [W-1:0]   w_cv;
    logic [W-1:0]   w_cw;
    logic [W*W-1:0] w_cd;
    logic [W-1:0]   w_arr_dep;
    logic           w_sel_any;
    logic           w_sel_wrong;
    logic [W-1:0]   w_sel;
    logic [W-1:0]   w_sel_dep;
    logic [W-1:0]   w_squash;
    logic [W-1:0]   w_nv;

    // Candidate build: the resolution currently on the outputs filters the table and arrivals
    always_comb begin
        w_clr     = (r_state == BR_PR_CORRECT) ? r_bit : '0;
        w_kill    = (r_state == BR_PR_WRONG)   ? r_bit : '0;
        w_cv      = '0;
        w_cw      = '0;
        w_cd      = '0;
        w_arr_dep = '0;
        for (int i = 0; i < W; i++) begin
            if (r_tv[i] && ((r_td[i*W +: W] & w_kill) == '0)) begin
                w_cv[i]        = 1'b1;
                w_cw[i]        = r_tw[i];
                w_cd[i*W +: W] = r_td[i*W +: W] & ~w_clr;
            end
        end
        // Descending port order lets the lower port win a duplicated bit
        for (int k = NUM_BR_PORT - 1; k >= 0; k--) begin
            w_arr_dep = fu_br_dep_mask_i[k*W +: W];
            for (int i = 0; i < W; i++) begin
                if (fu_br_valid_i[k] && fu_br_bit_i[k*W + i] && !r_tv[i] &&
                    ((w_arr_dep & w_kill) == '0)) begin
                    w_cv[i]        = 1'b1;
                    w_cw[i]        = fu_br_wrong_i[k];
                    w_cd[i*W +: W] = w_arr_dep & ~w_clr;
                end
            end
        end
    end

    br_oldest_sel #(
        .W (W)
    ) u_sel (
        .cand_valid (w_cv),
        .cand_wrong (w_cw),
        .cand_dep   (w_cd),
        .sel_any    (w_sel_any),
        .sel_wrong  (w_sel_wrong),
        .sel_bit    (w_sel)
    );

    always_comb begin
        w_sel_dep = '0;
        w_squash  = w_sel_wrong ? w_sel : '0;
        w_nv      = '0;
        for (int i = 0; i < W; i++) begin
            if (w_sel[i]) begin
                w_sel_dep = w_sel_dep | w_cd[i*W +: W];
            end
            w_nv[i] = w_cv[i] && !w_sel[i] && ((w_cd[i*W +: W] & w_squash) == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tv    <= '0;
            r_tw    <= '0;
            r_td    <= '0;
            r_state <= BR_NONE;
            r_bit   <= '0;
            r_dep   <= '0;
        end else begin
            r_tv    <= w_nv;
            r_tw    <= w_cw;
            r_td    <= w_cd;
            r_state <= !w_sel_any ? BR_NONE : (w_sel_wrong ? BR_PR_WRONG : BR_PR_CORRECT);
            r_bit   <= w_sel;
            r_dep   <= w_sel_dep;
        end
    end

    assign br_state_o    = r_state;
    assign br_bit_o      = r_bit;
    assign br_dep_mask_o = r_dep;
    assign pend_o        = r_tv;

endmodule

`default_nettype wire

// File: tb/tb_br_resolve_arb.sv
// ============================================================================
// Module  : tb_br_resolve_arb
// Brief   : Scoreboard bench: directed cases plus randomized program-ordered epochs.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_br_resolve_arb;
    import br_resolve_arb_pkg::*;

    localparam int W = 4;
    localparam int P = 2;

    typedef struct {
        int          slot;
        bit          wrong;
        logic [W-1:0] dep;
    } ent_t;

    typedef struct {
        logic [1:0]   st;
        logic [W-1:0] bt;
        logic [W-1:0] dp;
        logic [W-1:0] pd;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [P-1:0]   fu_valid;
    logic [P-1:0]   fu_wrong;
    logic [P*W-1:0] fu_bit;
    logic [P*W-1:0] fu_dep;
    logic [1:0]     br_state;
    logic [W-1:0]   br_bit;
    logic [W-1:0]   br_dep;
    logic [W-1:0]   pend;

    always #5 clk = ~clk;

    br_resolve_arb #(
        .BR_MASK_W   (W),
        .NUM_BR_PORT (P),
        .BR_STATE_W  (2)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fu_br_valid_i    (fu_valid),
        .fu_br_wrong_i    (fu_wrong),
        .fu_br_bit_i      (fu_bit),
        .fu_br_dep_mask_i (fu_dep),
        .br_state_o       (br_state),
        .br_bit_o         (br_bit),
        .br_dep_mask_o    (br_dep),
        .pend_o           (pend)
    );

    exp_t sb[$];
    exp_t mon_ex;
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_cycle  = 0;

    // Reference model: list of pending resolutions plus the resolution currently shown
    ent_t         m_tab[$];
    logic [1:0]   m_state;
    logic [W-1:0] m_bit;
    logic [W-1:0] m_dep;
    logic [W-1:0] m_picked;
    logic [W-1:0] m_wrong_picked;

    function automatic logic [W-1:0] slot_bit(input int s);
        logic [W-1:0] r;
        r    = '0;
        r[s] = 1'b1;
        return r;
    endfunction

    function automatic int onehot_idx(input logic [W-1:0] b);
        for (int i = 0; i < W; i++) if (b[i]) return i;
        return 0;
    endfunction

    function automatic logic [W-1:0] tab_bits();
        logic [W-1:0] r;
        r = '0;
        foreach (m_tab[j]) r = r | slot_bit(m_tab[j].slot);
        return r;
    endfunction

    task automatic model_step(input bit r, input logic [P-1:0] v, input logic [P-1:0] w,
                              input logic [P*W-1:0] b, input logic [P*W-1:0] d);
        ent_t cand[$];
        ent_t e;
        int pick;
        logic [W-1:0] wrong_bits;
        logic [W-1:0] arrived;
        logic [W-1:0] bb;
        logic [W-1:0] dd;
        if (r) begin
            m_tab.delete();
            m_state = BR_NONE;
            m_bit   = '0;
            m_dep   = '0;
            return;
        end
        foreach (m_tab[j]) begin
            e = m_tab[j];
            if (m_state == BR_PR_WRONG && (e.dep & m_bit) != '0) continue;
            if (m_state == BR_PR_CORRECT) e.dep = e.dep & ~m_bit;
            cand.push_back(e);
        end
        arrived = '0;
        for (int k = 0; k < P; k++) begin
            if (!v[k]) continue;
            bb = b[k*W +: W];
            dd = d[k*W +: W];
            if ((bb & (tab_bits() | arrived)) != '0) continue;
            if (m_state == BR_PR_WRONG && (dd & m_bit) != '0) continue;
            if (m_state == BR_PR_CORRECT) dd = dd & ~m_bit;
            e.slot  = onehot_idx(bb);
            e.wrong = w[k];
            e.dep   = dd;
            arrived = arrived | bb;
            cand.push_back(e);
        end
        wrong_bits = '0;
        foreach (cand[j]) if (cand[j].wrong) wrong_bits = wrong_bits | slot_bit(cand[j].slot);
        pick = -1;
        if (wrong_bits != '0) begin
            foreach (cand[j])
                if (pick < 0 && cand[j].wrong && (cand[j].dep & wrong_bits) == '0) pick = j;
        end else begin
            foreach (cand[j])
                if (pick < 0 || cand[j].slot < cand[pick].slot) pick = j;
        end
        if (pick < 0) begin
            m_state = BR_NONE;
            m_bit   = '0;
            m_dep   = '0;
            m_tab   = cand;
            return;
        end
        e       = cand[pick];
        m_state = e.wrong ? BR_PR_WRONG : BR_PR_CORRECT;
        m_bit   = slot_bit(e.slot);
        m_dep   = e.dep;
        m_picked = m_picked | m_bit;
        if (e.wrong) m_wrong_picked = m_wrong_picked | m_bit;
        m_tab.delete();
        foreach (cand[j])
            if (j != pick && !(e.wrong && (cand[j].dep & m_bit) != '0)) m_tab.push_back(cand[j]);
    endtask

    task automatic cycle(input bit r, input logic [P-1:0] v, input logic [P-1:0] w,
                         input logic [P*W-1:0] b, input logic [P*W-1:0] d,
                         input bit use_const, input exp_t ce);
        exp_t ex;
        rst      = r;
        fu_valid = v;
        fu_wrong = w;
        fu_bit   = b;
        fu_dep   = d;
        if (!r) begin
            assert (!(v[0] && v[1] && b[W-1:0] == b[2*W-1:W]))
                else $error("illegal stimulus: both ports carry the same branch bit");
            for (int k = 0; k < P; k++)
                assert (!(v[k] && (b[k*W +: W] & tab_bits()) != '0))
                    else $error("illegal stimulus: arrival for an already pending slot");
        end
        model_step(r, v, w, b, d);
        if (use_const) begin
            ex = ce;
        end else begin
            ex.st = m_state;
            ex.bt = m_bit;
            ex.dp = m_dep;
            ex.pd = tab_bits();
        end
        sb.push_back(ex);
        @(negedge clk);
    endtask

    // Directed cycle with hand-derived expected outputs after the next edge
    task automatic dcyc(input bit r,
                        input bit v0, input bit w0, input logic [W-1:0] b0, input logic [W-1:0] d0,
                        input bit v1, input bit w1, input logic [W-1:0] b1, input logic [W-1:0] d1,
                        input logic [1:0] st, input logic [W-1:0] bt,
                        input logic [W-1:0] dp, input logic [W-1:0] pd);
        exp_t ce;
        ce.st = st;
        ce.bt = bt;
        ce.dp = dp;
        ce.pd = pd;
        cycle(r, {v1, v0}, {w1, w0}, {b1, b0}, {d1, d0}, 1'b1, ce);
    endtask

    task automatic idle_exp_none(input int n);
        for (int i = 0; i < n; i++)
            dcyc(0, 0, 0, 4'b0, 4'b0, 0, 0, 4'b0, 4'b0, BR_NONE, 4'b0, 4'b0, 4'b0);
    endtask

    // One epoch: up to W branches with a random program order; deps list older unresolved ones
    task automatic run_epoch();
        int   order[W];
        bit   wr[W];
        bit   sent[W];
        int   n;
        int   tmp;
        int   j;
        int   guard;
        int   elig[$];
        int   chosen[P];
        bit   r;
        bit   blocked;
        bit   done;
        logic [P-1:0]   v;
        logic [P-1:0]   w;
        logic [P*W-1:0] b;
        logic [P*W-1:0] d;
        logic [W-1:0]   dep;
        exp_t dummy;
        dummy = '{default: '0};
        for (int i = 0; i < W; i++) order[i] = i;
        for (int i = W - 1; i > 0; i--) begin
            j        = $urandom_range(0, i);
            tmp      = order[i];
            order[i] = order[j];
            order[j] = tmp;
        end
        n = $urandom_range(1, W);
        for (int i = 0; i < W; i++) begin
            wr[i]   = ($urandom_range(0, 3) == 0);
            sent[i] = (i >= n);
        end
        m_picked       = '0;
        m_wrong_picked = '0;
        guard          = 0;
        done           = 1'b0;
        while (!done && guard < 40) begin
            v = '0; w = '0; b = '0; d = '0;
            r = ($urandom_range(0, 59) == 0);
            for (int a = 0; a < n; a++) begin
                blocked = 1'b0;
                for (int o = 0; o < a; o++) if (m_wrong_picked[order[o]]) blocked = 1'b1;
                if (blocked) sent[a] = 1'b1;
            end
            for (int k = 0; k < P; k++) begin
                chosen[k] = -1;
                elig.delete();
                for (int a = 0; a < n; a++)
                    if (!sent[a] && !(k == 1 && chosen[0] == a)) elig.push_back(a);
                if (elig.size() > 0 && $urandom_range(0, 9) < 6) begin
                    chosen[k] = elig[$urandom_range(0, elig.size() - 1)];
                    dep = '0;
                    for (int o = 0; o < chosen[k]; o++)
                        if (!m_picked[order[o]]) dep = dep | slot_bit(order[o]);
                    v[k]         = 1'b1;
                    w[k]         = wr[chosen[k]];
                    b[k*W +: W]  = slot_bit(order[chosen[k]]);
                    d[k*W +: W]  = dep;
                end
            end
            for (int k = 0; k < P; k++) if (chosen[k] >= 0) sent[chosen[k]] = 1'b1;
            if (r) for (int a = 0; a < W; a++) sent[a] = 1'b1;
            cycle(r, v, w, b, d, 1'b0, dummy);
            guard++;
            done = (m_tab.size() == 0) && (m_state == BR_NONE);
            for (int a = 0; a < W; a++) if (!sent[a]) done = 1'b0;
        end
        cycle(0, '0, '0, '0, '0, 1'b0, dummy);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            n_cycle++;
            if (sb.size() > 0) begin
                mon_ex = sb.pop_front();
                n_checks++;
                if (br_state !== mon_ex.st || br_bit !== mon_ex.bt ||
                    br_dep !== mon_ex.dp || pend !== mon_ex.pd) begin
                    n_errors++;
                    $display("FAIL out_cmp cycle %0d: state/bit/dep/pend got %b/%b/%b/%b required %b/%b/%b/%b",
                             n_cycle, br_state, br_bit, br_dep, pend,
                             mon_ex.st, mon_ex.bt, mon_ex.dp, mon_ex.pd);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        fu_valid = '0;
        fu_wrong = '0;
        fu_bit   = '0;
        fu_dep   = '0;
        // Reset state
        dcyc(1, 0, 0, 4'b0, 4'b0, 0, 0, 4'b0, 4'b0, BR_NONE, 4'b0, 4'b0, 4'b0);
        dcyc(1, 0, 0, 4'b0, 4'b0, 0, 0, 4'b0, 4'b0, BR_NONE, 4'b0, 4'b0, 4'b0);
        // Single correct resolution
        dcyc(0, 1, 0, 4'b0010, 4'b0, 0, 0, 4'b0, 4'b0, BR_PR_CORRECT, 4'b0010, 4'b0, 4'b0);
        idle_exp_none(1);
        // Wrong beats correct; the correct one follows
        dcyc(0, 1, 0, 4'b0001, 4'b0, 1, 1, 4'b0100, 4'b0001, BR_PR_WRONG, 4'b0100, 4'b0001, 4'b0001);
        dcyc(0, 0, 0, 4'b0, 4'b0, 0, 0, 4'b0, 4'b0, BR_PR_CORRECT, 4'b0001, 4'b0, 4'b0);
        idle_exp_none(1);
        // Oldest wrong issues and squashes the younger wrong
        dcyc(0, 1, 1, 4'b1000, 4'b0011, 1, 1, 4'b0010, 4'b0001, BR_PR_WRONG, 4'b0010, 4'b0001, 4'b0);
        idle_exp_none(1);
        // Correct issue clears its bit from an arriving dep mask
        dcyc(0, 1, 0, 4'b0001, 4'b0, 0, 0, 4'b0, 4'b0, BR_PR_CORRECT, 4'b0001, 4'b0, 4'b0);
        dcyc(0, 1, 0, 4'b1000, 4'b0011, 1, 0, 4'b0100, 4'b0, BR_PR_CORRECT, 4'b0100, 4'b0, 4'b1000);
        dcyc(0, 0, 0, 4'b0, 4'b0, 0, 0, 4'b0, 4'b0, BR_PR_CORRECT, 4'b1000, 4'b0010, 4'b0);
        idle_exp_none(1);
        // Fill three entries, then reset drops them and ignores the reset-cycle arrival
        dcyc(0, 1, 0, 4'b0001, 4'b0, 1, 0, 4'b0010, 4'b0, BR_PR_CORRECT, 4'b0001, 4'b0, 4'b0010);
        dcyc(0, 1, 0, 4'b0100, 4'b0, 1, 0, 4'b1000, 4'b0, BR_PR_CORRECT, 4'b0010, 4'b0, 4'b1100);
        dcyc(0, 1, 0, 4'b0001, 4'b0, 1, 0, 4'b0010, 4'b0, BR_PR_CORRECT, 4'b0001, 4'b0, 4'b1110);
        dcyc(1, 1, 1, 4'b0001, 4'b0, 0, 0, 4'b0, 4'b0, BR_NONE, 4'b0, 4'b0, 4'b0);
        idle_exp_none(2);
        // Long idle
        idle_exp_none(10);
        for (int e = 0; e < 300; e++) run_epoch();
        @(posedge clk);
        #2;
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
